instr_fetch_unit: RTL

- Initiator side of the instruction-memory interface.
- Owns the fetch PC and drives a byte address to the combinational instruction memory.
- Captures the returned 32-bit word into a small prefetch queue and hands {pc, instr} to decode over a valid/ready handshake.
- Handles branch redirects and flags misaligned or out-of-bounds fetches instead of issuing them.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and address check for the instruction fetch unit
// Contents: fetch_state_t (FETCH/FAULT), INSTR_BYTES, fetch_entry_t {pc, instr},
// is_bad_addr() returning 1 for a misaligned or out-of-memory fetch address.
`timescale 1ns/1ps
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    // Default-width entry; the top builds its own entry type from its parameters.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // The last byte is computed one bit wider so a word near the top of the
    // address space cannot wrap back into range.
    function automatic logic is_bad_addr(input logic [63:0] addr, input logic [63:0] mem_bytes);
        logic [64:0] last_byte;
        last_byte = {1'b0, addr} + 65'(INSTR_BYTES - 1);
        return (addr[1:0] != 2'b00) || (last_byte >= {1'b0, mem_bytes});
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO of fetch entries
// Ports: clk, reset (sync, active-high), flush (clears, beats push/pop),
// push/push_data (enqueue), pop (dequeue head), head (current head entry),
// count (occupancy). Push while full is legal only together with pop.
`timescale 1ns/1ps
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full with a pop, the write slot is the head slot being retired.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, redirect/fault FSM and prefetch queue front end
// Ports: clk, reset (sync, active-high); imem_addr/imem_instr (combinational
// instruction memory); redirect_valid/redirect_target (new PC, flushes queue);
// out_valid/out_ready/out_instr/out_pc (decode handshake); fault/fault_addr.
// Optional macro FETCH_TRACE_EN: prints each delivered instruction and each
// fault entry along with a delivered-instruction count.
`timescale 1ns/1ps
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                INSTR_W   = 32,
    parameter int                MEM_BYTES = 1024,
    parameter int                QDEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_addr
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    logic              bad;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    entry_t            head;
    entry_t            push_data;

    assign bad       = is_bad_addr(64'(fetch_pc_q), 64'(MEM_BYTES));
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = (state_q == FETCH) && !bad && !redirect_valid &&
                       ((int'(count) < QDEPTH) || pop);
    assign push_data = '{pc: fetch_pc_q, instr: imem_instr};

    fetch_queue #(
        .DEPTH   (QDEPTH),
        .entry_t (entry_t),
        .CNT_W   (CNT_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (redirect_valid) begin
            state_d    = FETCH;
            fetch_pc_d = redirect_target;
            fault_d    = 1'b0;
        end else if (state_q == FETCH && bad) begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_addr_d = fetch_pc_q;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign imem_addr  = fetch_pc_q;
    assign out_instr  = head.instr;
    assign out_pc     = head.pc;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

    assert property (@(posedge clk) disable iff (reset) push |-> !$isunknown(imem_instr));
    assert property (@(posedge clk) disable iff (reset)
                     !$isunknown({redirect_valid, redirect_target, out_ready}));

`ifdef FETCH_TRACE_EN
    logic [31:0] delivered_q, delivered_d;

    always_comb begin
        delivered_d = delivered_q;
        if (pop) delivered_d = delivered_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) delivered_q <= '0;
        else       delivered_q <= delivered_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (pop)
                $display("%t ns fetch pc=%h instr=%b", $time, out_pc, out_instr);
            if (state_q == FETCH && state_d == FAULT)
                $display("%t ns fetch fault addr=%h delivered=%0d", $time, fault_addr_d, delivered_q);
        end
    end
`endif

endmodule
